// File: rtl/chart_sequencer_if.sv
// Bundle between the chart sequencer, its chart ROM, the frame/transport controls and the display path.
// The master side is the sequencer and the slave side is the surrounding system.
interface chart_sequencer_if #(
    parameter int ADDR_W  = 9,
    parameter int ROW_W   = 4,
    parameter int PHASE_W = 8
);
    logic               frame_clk;
    logic               start;
    logic               pause;
    logic [PHASE_W-1:0] tempo;
    logic [ADDR_W-1:0]  chart_len;
    logic [ADDR_W-1:0]  rom_addr;
    logic [ROW_W-1:0]   rom_data;
    logic [ROW_W-1:0]   note_row;
    logic               note_valid;
    logic [ADDR_W-1:0]  row_index;
    logic               playing;
    logic               done;

    modport master (
        input  frame_clk, start, pause, tempo, chart_len, rom_data,
        output rom_addr, note_row, note_valid, row_index, playing, done
    );

    modport slave (
        output frame_clk, start, pause, tempo, chart_len, rom_data,
        input  rom_addr, note_row, note_valid, row_index, playing, done
    );
endinterface

// File: rtl/chart_sequencer.sv
// Step-chart playback controller: paces reads of a synchronous chart ROM from a frame tick
// and a tempo phase accumulator, emitting one note row per advance.
module chart_sequencer #(
    parameter int ADDR_W  = 9,
    parameter int ROW_W   = 4,
    parameter int PHASE_W = 8,
    parameter int LEAD_IN = 60
) (
    input  logic              Clk,
    input  logic              reset,
    chart_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_PLAY, S_FETCH, S_EMIT, S_DONE
    } state_t;

    localparam int LEAD_W = (LEAD_IN > 2) ? $clog2(LEAD_IN) : 1;
    localparam logic [LEAD_W-1:0] LEAD_LAST = LEAD_W'((LEAD_IN > 0) ? LEAD_IN - 1 : 0);

    state_t             state, state_nxt;
    logic               frame_clk_d;
    logic               fe;
    logic               advance;
    logic               lead_end;
    logic               last_row;
    logic [PHASE_W:0]   sum;
    logic [PHASE_W-1:0] acc;
    logic [LEAD_W-1:0]  lead;
    logic [ADDR_W-1:0]  len_q;
    logic [ADDR_W-1:0]  rom_addr_q;
    logic [ROW_W-1:0]   note_row_q;
    logic               note_valid_q;
    logic [ADDR_W-1:0]  row_index_q;
    logic               playing_c;
    logic               done_c;

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        fe       = bus.frame_clk & ~frame_clk_d;
        advance  = fe & ~bus.pause;
        sum      = {1'b0, acc} + {1'b0, bus.tempo};
        last_row = (rom_addr_q == len_q - ADDR_W'(1));
        lead_end = 1'b0;
        if (LEAD_IN == 0)
            lead_end = 1'b1;
        else
            lead_end = advance && (lead == LEAD_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (bus.start) state_nxt = S_LEAD;
            S_LEAD:         if (lead_end) state_nxt = (len_q != '0) ? S_FETCH : S_DONE;
            S_PLAY:         if (advance && sum[PHASE_W]) state_nxt = S_FETCH;
            S_FETCH:        state_nxt = S_EMIT;
            S_EMIT:         state_nxt = last_row ? S_DONE : S_PLAY;
            default:        state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        playing_c = 1'b0;
        done_c    = 1'b0;
        case (state)
            S_LEAD, S_PLAY, S_FETCH, S_EMIT: playing_c = 1'b1;
            S_DONE:                          done_c    = 1'b1;
            default: ;
        endcase
    end

    // Datapath: fe arriving in the start cycle is dropped because IDLE/DONE ignore it.
    always_ff @(posedge Clk) begin
        if (reset) begin
            frame_clk_d  <= 1'b0;
            acc          <= '0;
            lead         <= '0;
            len_q        <= '0;
            rom_addr_q   <= '0;
            note_row_q   <= '0;
            note_valid_q <= 1'b0;
            row_index_q  <= '0;
        end else begin
            frame_clk_d  <= bus.frame_clk;
            note_valid_q <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        len_q      <= bus.chart_len;
                        acc        <= '0;
                        lead       <= '0;
                        rom_addr_q <= '0;
                    end
                end
                S_LEAD: if (advance) lead <= lead + LEAD_W'(1);
                S_PLAY: begin
                    if (advance) begin
                        acc <= sum[PHASE_W-1:0];
                        if (sum[PHASE_W]) rom_addr_q <= rom_addr_q + ADDR_W'(1);
                    end
                end
                S_EMIT: begin
                    note_row_q   <= bus.rom_data;
                    row_index_q  <= rom_addr_q;
                    note_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.note_row   = note_row_q;
    assign bus.note_valid = note_valid_q;
    assign bus.row_index  = row_index_q;
    assign bus.playing    = playing_c;
    assign bus.done       = done_c;
endmodule

// File: tb/tb_chart_sequencer.sv
// Randomized bench for chart_sequencer: a frame-level playback model predicts each emitted row,
// and a monitor pops the predictions whenever note_valid fires.
module tb_chart_sequencer;
    localparam int ADDR_W  = 9;
    localparam int ROW_W   = 4;
    localparam int PHASE_W = 8;
    localparam int LEAD_IN = 2;
    localparam int GAP     = 5;
    localparam int LAT     = 3;

    typedef enum {M_IDLE, M_LEAD, M_PLAY, M_DONE} mode_t;
    typedef struct {
        int row;
        int idx;
        int cyc;
    } exp_t;

    logic Clk = 1'b0;
    logic reset = 1'b1;
    always #5 Clk = ~Clk;

    chart_sequencer_if #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .PHASE_W(PHASE_W)) bus ();

    chart_sequencer #(
        .ADDR_W(ADDR_W), .ROW_W(ROW_W), .PHASE_W(PHASE_W), .LEAD_IN(LEAD_IN)
    ) dut (
        .Clk(Clk),
        .reset(reset),
        .bus(bus)
    );

    logic [ROW_W-1:0] rom_mem [0:(1<<ADDR_W)-1];
    always @(posedge Clk) bus.rom_data <= rom_mem[bus.rom_addr];

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    exp_t sb[$];

    mode_t m_mode;
    int m_acc, m_lead, m_len, m_row, m_last_idx, m_last_row;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every note_valid must match the oldest outstanding prediction.
    always @(negedge Clk) begin
        if (!reset && bus.note_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_note: got row %0d idx %0d expected no note_valid",
                         bus.note_row, bus.row_index);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("note_row", int'(bus.note_row), e.row);
                check("row_index", int'(bus.row_index), e.idx);
                check("latency", cyc - e.cyc, LAT);
            end
        end
    end

    task automatic model_emit(input int r);
        exp_t e;
        m_row      = r;
        m_last_idx = r;
        m_last_row = int'(rom_mem[r]);
        e.row = m_last_row;
        e.idx = r;
        e.cyc = cyc;
        sb.push_back(e);
        m_mode = (r == m_len - 1) ? M_DONE : M_PLAY;
    endtask

    task automatic model_fe(input bit p);
        if (!p) begin
            case (m_mode)
                M_LEAD: begin
                    m_lead++;
                    if (m_lead == LEAD_IN) begin
                        if (m_len == 0) m_mode = M_DONE;
                        else model_emit(0);
                    end
                end
                M_PLAY: begin
                    m_acc += int'(bus.tempo);
                    if (m_acc >= (1 << PHASE_W)) begin
                        m_acc -= (1 << PHASE_W);
                        model_emit(m_row + 1);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_start(output bit accepted);
        accepted = (m_mode == M_IDLE || m_mode == M_DONE);
        if (accepted) begin
            m_mode = M_LEAD;
            m_lead = 0;
            m_acc  = 0;
            m_len  = int'(bus.chart_len);
            m_row  = 0;
        end
    endtask

    task automatic status_check();
        check("playing", int'(bus.playing), int'(m_mode == M_LEAD || m_mode == M_PLAY));
        check("done", int'(bus.done), int'(m_mode == M_DONE));
        check("rom_addr", int'(bus.rom_addr), m_row);
        check("held_row", int'(bus.note_row), m_last_row);
        check("held_index", int'(bus.row_index), m_last_idx);
    endtask

    task automatic do_reset();
        bus.frame_clk = 1'b0;
        bus.start     = 1'b0;
        reset         = 1'b1;
        sb.delete();
        m_mode = M_IDLE;
        m_acc = 0; m_lead = 0; m_len = 0; m_row = 0; m_last_idx = 0; m_last_row = 0;
        @(negedge Clk);
        check("rst_note_valid", int'(bus.note_valid), 0);
        status_check();
        reset = 1'b0;
        @(negedge Clk);
    endtask

    task automatic frame(input bit p, input bit with_start);
        bit accepted;
        accepted      = 1'b0;
        bus.pause     = p;
        bus.frame_clk = 1'b1;
        if (with_start) begin
            bus.start = 1'b1;
            model_start(accepted);
        end
        if (!accepted) model_fe(p);
        @(negedge Clk);
        bus.frame_clk = 1'b0;
        bus.start     = 1'b0;
        repeat (GAP) @(negedge Clk);
        status_check();
    endtask

    task automatic do_start(input int len);
        bit accepted;
        bus.chart_len = ADDR_W'(len);
        bus.start     = 1'b1;
        model_start(accepted);
        @(negedge Clk);
        bus.start = 1'b0;
        repeat (2) @(negedge Clk);
        status_check();
    endtask

    task automatic fill_rom();
        for (int i = 0; i < (1 << ADDR_W); i++) rom_mem[i] = ROW_W'($urandom);
    endtask

    initial begin
        bit hit;
        int n;
        bus.frame_clk = 1'b0;
        bus.start     = 1'b0;
        bus.pause     = 1'b0;
        bus.tempo     = '0;
        bus.chart_len = '0;
        fill_rom();
        rom_mem[0] = 4'b1111;
        rom_mem[1] = 4'b0000;
        rom_mem[2] = 4'b1010;
        do_reset();

        // Three-row chart at near full rate.
        bus.tempo = 8'd255;
        do_start(3);
        repeat (8) frame(1'b0, 1'b0);

        // Half rate: one row every second frame.
        bus.tempo = 8'd128;
        do_start(6);
        repeat (16) frame(1'b0, 1'b0);

        // Pause for 5 frames mid-play, then a start pulse that must be ignored.
        do_start(8);
        repeat (5) frame(1'b0, 1'b0);
        repeat (5) frame(1'b1, 1'b0);
        frame(1'b0, 1'b1);
        repeat (14) frame(1'b0, 1'b0);

        // Empty chart: lead-in then straight to DONE.
        do_start(0);
        repeat (LEAD_IN + 2) frame(1'b0, 1'b0);

        // Start coinciding with a frame edge in DONE restarts at row 0.
        bus.tempo     = 8'd255;
        bus.chart_len = ADDR_W'(3);
        frame(1'b0, 1'b1);
        repeat (8) frame(1'b0, 1'b0);

        // Randomized runs: random chart, tempo, pauses and stray starts.
        for (int run = 0; run < 6; run++) begin
            fill_rom();
            bus.tempo = PHASE_W'($urandom_range(0, 255));
            do_start($urandom_range(0, 10));
            for (int f = 0; f < 30; f++) begin
                bus.chart_len = ADDR_W'($urandom_range(0, 10));
                frame($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
            end
        end

        // Reset while a fetch is in flight.
        bus.tempo = 8'd200;
        do_start(8);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            n             = sb.size();
            bus.pause     = 1'b0;
            bus.frame_clk = 1'b1;
            model_fe(1'b0);
            @(negedge Clk);
            bus.frame_clk = 1'b0;
            if (sb.size() > n) begin
                hit = 1'b1;
                do_reset();
            end else begin
                repeat (GAP) @(negedge Clk);
            end
        end
        check("reset_in_fetch_reached", int'(hit), 1);

        // Zero tempo after restart: only the lead-in row, then playback holds.
        bus.tempo = 8'd0;
        do_start(3);
        repeat (10) frame(1'b0, 1'b0);

        repeat (6) @(negedge Clk);
        check("scoreboard_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
